fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage between the program ROM and the decoder. Holds the PC,
//  runs the ROM cs/ready read handshake, and assembles each two-word instruction
//  (opcode word, then operand word) into one record for the decoder.
//  Branch redirects from execute reload the PC and flush the in-flight fetch.
// PARAMETERS
//  ADDR_W      16      PC / mem_addr width; PC wraps modulo 2**ADDR_W
//  DATA_W      16      ROM word width
//  RESET_PC    16'h0   PC value after reset
//  TIMEOUT_CYC 15      max cycles in WAIT_LO+WAIT_HI (FETCH_TIMEOUT_EN only)
// PORTS
//  clk           in   1       rising-edge clock
//  rst_n         in   1       reset, asynchronous, active-low
//  run           in   1       1 = fetch continuously; 0 = stop after current instruction
//  mem_cs        out  1       ROM chip select, registered, exactly one cycle per word
//  mem_addr      out  ADDR_W  ROM word address, registered
//  mem_ready     in   1       ROM ready (drops the cycle after cs is sampled)
//  mem_data      in   DATA_W  ROM read data, valid only when ready returns high
//  br_en         in   1       branch redirect strobe
//  br_target     in   ADDR_W  new PC (word address of an opcode word)
//  instr_valid   out  1       instruction record valid
//  instr_opcode  out  DATA_W  first word
//  instr_operand out  DATA_W  second word
//  instr_pc      out  ADDR_W  address of opcode word
//  instr_accept  in   1       decoder takes record at edge where valid&accept
//  busy          out  1       state != IDLE
//  fetch_err     out  1       bus timeout flag (0 when macro absent)
// BEHAVIOUR
//  - Reset: state IDLE, pc=RESET_PC, word=0, mem_cs=0, mem_addr=RESET_PC,
//    instr_valid=0, instr_opcode/operand=0, instr_pc=RESET_PC, fetch_err=0,
//    settle counter=0.
//  - Settle: 2-bit counter runs after reset; IDLE->REQ requires settle done
//    (2 cycles) AND mem_ready=1 AND run=1 (lets ROM finish a cut-off read).
//  - FSM IDLE->REQ->WAIT_LO->WAIT_HI->(REQ|HOLD):
//    REQ: mem_cs=1, mem_addr=pc for this cycle only; -> WAIT_LO.
//    WAIT_LO: stay until mem_ready=0 sampled; -> WAIT_HI.
//    WAIT_HI: stay until mem_ready=1 sampled; capture mem_data at that edge.
//      word=0: opcode<=data, instr_pc<=pc, pc<=pc+1, word<=1, -> REQ.
//      word=1: operand<=data, pc<=pc+1, word<=0, instr_valid<=1, -> HOLD.
//    HOLD: outputs frozen, no mem_cs; on valid&accept: valid<=0, -> REQ if run
//      else IDLE.
//  - Latency: instr_valid rises on the 6th edge after the edge leaving IDLE;
//    sustained rate 1 instruction / 7 cycles with accept tied high.
//  - PC arithmetic: unsigned, +1 per word, wraps 0xFFFF->0x0000; no alignment check.
//  - Branch (br_en sampled any state): pc<=br_target, word<=0.
//    IDLE: stay. HOLD: valid<=0 same edge, -> REQ if run. REQ/WAIT_LO/WAIT_HI:
//    set flush; transaction completes normally, captured data discarded, no
//    instr_valid, then -> REQ at br_target. br_en beats instr_accept same edge.
//  - run=0 mid-instruction: instruction completes to HOLD, then IDLE after accept.
//  - Reset mid-transaction: immediate async return to reset values; settle rule
//    prevents issuing cs while ROM is still mid-read.
// CONFIGURATION
//  FETCH_TIMEOUT_EN defined: cycle counter cleared on REQ, counts in WAIT_LO/HI;
//    at TIMEOUT_CYC: fetch_err<=1 (sticky until br_en or reset), word<=0,
//    pc<=instr_pc-start of aborted instruction, -> IDLE (retries when run).
//  Not defined: no counter, fetch_err tied 0, WAIT states wait indefinitely.
// TESTING
//  1 mem[0]=0x0028,mem[1]=0x0005, run=1, accept=1 -> cs at addr 0 then 1; valid on
//    6th edge after leaving IDLE, opcode 0x0028, operand 0x0005, instr_pc 0x0000.
//  2 accept=0 for 10 cycles in HOLD -> valid/record stable, no mem_cs; accept=1 ->
//    next edge REQ, mem_cs=1 with mem_addr 0x0002.
//  3 br_en, br_target=0x0004 while in HOLD -> valid low next edge, next cs at 0x0004.
//  4 br_en target 0x000A during WAIT_HI of operand at addr 0x0007 -> no valid for
//    it; next cs at 0x000A,0x000B; instr_pc 0x000A.
//  5 RESET_PC=0xFFFE -> fetches 0xFFFE,0xFFFF, next cs at 0x0000; rst_n low in
//    WAIT_LO -> outputs reset at once, no cs for 2 cycles after release.
//  6 FETCH_TIMEOUT_EN, model holds ready=1 -> fetch_err=1 after 15 cycles, IDLE;
//    br_en clears it.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: PC, ROM cs/ready handshake, two-word instruction assembly
// Optional bus timeout abort enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit #(
  parameter int unsigned       ADDR_W      = 16,
  parameter int unsigned       DATA_W      = 16,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int unsigned       TIMEOUT_CYC = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic              mem_cs,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              br_en,
  input  logic [ADDR_W-1:0] br_target,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr_opcode,
  output logic [DATA_W-1:0] instr_operand,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_accept,
  output logic              busy,
  output logic              fetch_err
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT_LO, WAIT_HI, HOLD} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_inc;
  logic              word;
  logic              flush;
  logic [1:0]        settle;
  logic              settle_done;

  assign pc_inc      = pc + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign settle_done = (settle == 2'd2);
  assign busy        = (state != IDLE);

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [TCNT_W-1:0] tcnt;
  logic              timeout_hit;

  // A completing WAIT_HI (ready seen high) is never aborted.
  assign timeout_hit = (state == WAIT_LO || (state == WAIT_HI && !mem_ready)) &&
                       (tcnt == TCNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt      <= '0;
      fetch_err <= 1'b0;
    end else begin
      if (state == REQ)
        tcnt <= '0;
      else if (state == WAIT_LO || state == WAIT_HI)
        tcnt <= tcnt + TCNT_W'(1);
      if (br_en)
        fetch_err <= 1'b0;
      else if (timeout_hit)
        fetch_err <= 1'b1;
    end
  end
`else
  assign fetch_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      word          <= 1'b0;
      flush         <= 1'b0;
      settle        <= 2'd0;
      mem_cs        <= 1'b0;
      mem_addr      <= RESET_PC;
      instr_valid   <= 1'b0;
      instr_opcode  <= '0;
      instr_operand <= '0;
      instr_pc      <= RESET_PC;
    end else begin
      if (!settle_done)
        settle <= settle + 2'd1;
      mem_cs <= 1'b0;

      case (state)
        IDLE: begin
          if (br_en) begin
            pc   <= br_target;
            word <= 1'b0;
          end else if (settle_done && mem_ready && run) begin
            state    <= REQ;
            mem_cs   <= 1'b1;
            mem_addr <= pc;
          end
        end

        REQ: begin
          state <= WAIT_LO;
          if (br_en) begin
            pc    <= br_target;
            word  <= 1'b0;
            flush <= 1'b1;
          end
        end

        WAIT_LO: begin
          if (!mem_ready)
            state <= WAIT_HI;
          if (br_en) begin
            pc    <= br_target;
            word  <= 1'b0;
            flush <= 1'b1;
          end
        end

        WAIT_HI: begin
          if (mem_ready) begin
            // A redirect pending or arriving now discards this word.
            if (flush || br_en) begin
              flush    <= 1'b0;
              state    <= REQ;
              mem_cs   <= 1'b1;
              mem_addr <= br_en ? br_target : pc;
              if (br_en) begin
                pc   <= br_target;
                word <= 1'b0;
              end
            end else if (!word) begin
              instr_opcode <= mem_data;
              instr_pc     <= pc;
              pc           <= pc_inc;
              word         <= 1'b1;
              state        <= REQ;
              mem_cs       <= 1'b1;
              mem_addr     <= pc_inc;
            end else begin
              instr_operand <= mem_data;
              pc            <= pc_inc;
              word          <= 1'b0;
              instr_valid   <= 1'b1;
              state         <= HOLD;
            end
          end else if (br_en) begin
            pc    <= br_target;
            word  <= 1'b0;
            flush <= 1'b1;
          end
        end

        HOLD: begin
          if (br_en || instr_accept) begin
            instr_valid <= 1'b0;
            if (br_en) begin
              pc   <= br_target;
              word <= 1'b0;
            end
            if (run) begin
              state    <= REQ;
              mem_cs   <= 1'b1;
              mem_addr <= br_en ? br_target : pc;
            end else begin
              state <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase

`ifdef FETCH_TIMEOUT_EN
      // Abort restarts the whole instruction from its opcode word.
      if (timeout_hit) begin
        state <= IDLE;
        word  <= 1'b0;
        flush <= 1'b0;
        pc    <= br_en ? br_target : (word ? instr_pc : pc);
      end
`endif
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit with a behavioural ROM
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        mem_cs;
  logic [15:0] mem_addr;
  logic        mem_ready = 1'b1;
  logic [15:0] mem_data = 16'h0;
  logic        br_en = 1'b0;
  logic [15:0] br_target = 16'h0;
  logic        instr_valid;
  logic [15:0] instr_opcode;
  logic [15:0] instr_operand;
  logic [15:0] instr_pc;
  logic        instr_accept = 1'b0;
  logic        busy;
  logic        fetch_err;

  int n_checks = 0;
  int n_fail = 0;

  fetch_unit #(
    .ADDR_W(16), .DATA_W(16), .RESET_PC(16'h0000), .TIMEOUT_CYC(15)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .mem_cs(mem_cs), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_data(mem_data),
    .br_en(br_en), .br_target(br_target),
    .instr_valid(instr_valid), .instr_opcode(instr_opcode), .instr_operand(instr_operand),
    .instr_pc(instr_pc), .instr_accept(instr_accept), .busy(busy), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  // ROM: ready drops after cs is sampled, returns high with data after lat cycles.
  logic [15:0] rom [0:65535];
  int          lat = 1;
  bit          rom_stuck = 1'b0;
  int          rom_cnt = 0;
  logic [15:0] rom_a = 16'h0;
  logic [15:0] cs_log [$];

  always @(posedge clk) begin
    if (rom_stuck) begin
      mem_ready <= 1'b1;
    end else if (mem_cs === 1'b1) begin
      mem_ready <= 1'b0;
      rom_cnt   <= lat;
      rom_a     <= mem_addr;
    end else if (!mem_ready) begin
      if (rom_cnt <= 1) begin
        mem_ready <= 1'b1;
        mem_data  <= rom[rom_a];
      end else begin
        rom_cnt <= rom_cnt - 1;
      end
    end
  end

  always @(posedge clk)
    if (mem_cs === 1'b1) cs_log.push_back(mem_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max_cyc, output int n);
    n = 0;
    while (instr_valid !== 1'b1 && n < max_cyc) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({mem_cs, instr_valid, busy, fetch_err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 0000", {mem_cs, instr_valid, busy, fetch_err});
    end
    n_checks++;
    if (mem_addr !== 16'h0000 || instr_pc !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_addr: got mem_addr=%h instr_pc=%h expected 0000/0000", mem_addr, instr_pc);
    end
    n_checks++;
    if (instr_opcode !== 16'h0 || instr_operand !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_record: got %h/%h expected 0000/0000", instr_opcode, instr_operand);
    end
    run = 1'b1;
    cs_log.delete();
    rst_n = 1'b1;
  endtask

  task automatic test_first_fetch();
    int n;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (mem_cs !== 1'b0) begin
        n_fail++;
        $display("FAIL settle_cs%0d: got %b expected 0", i, mem_cs);
      end
    end
    tick();
    n_checks++;
    if (mem_cs !== 1'b1 || mem_addr !== 16'h0000 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL first_req: got cs=%b addr=%h busy=%b expected 1/0000/1", mem_cs, mem_addr, busy);
    end
    wait_valid(20, n);
    n_checks++;
    if (instr_valid !== 1'b1 || n !== 6) begin
      n_fail++;
      $display("FAIL first_latency: got %0d edges valid=%b expected 6 edges valid=1", n, instr_valid);
    end
    n_checks++;
    if (instr_opcode !== 16'h0028 || instr_operand !== 16'h0005 || instr_pc !== 16'h0000) begin
      n_fail++;
      $display("FAIL first_record: got %h/%h pc=%h expected 0028/0005 pc=0000",
               instr_opcode, instr_operand, instr_pc);
    end
    n_checks++;
    if (cs_log.size() != 2 || cs_log[0] !== 16'h0000 || cs_log[1] !== 16'h0001) begin
      n_fail++;
      $display("FAIL first_cs_addrs: got %0d entries expected 2 (0000,0001)", cs_log.size());
    end
  endtask

  task automatic test_hold();
    int n;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if (instr_valid !== 1'b1 || mem_cs !== 1'b0 || instr_opcode !== 16'h0028 ||
          instr_operand !== 16'h0005 || instr_pc !== 16'h0000) begin
        n_fail++;
        $display("FAIL hold_stable%0d: got v=%b cs=%b %h/%h pc=%h expected 1/0 0028/0005 pc=0000",
                 i, instr_valid, mem_cs, instr_opcode, instr_operand, instr_pc);
      end
    end
    instr_accept = 1'b1;
    tick();
    instr_accept = 1'b0;
    n_checks++;
    if (instr_valid !== 1'b0 || mem_cs !== 1'b1 || mem_addr !== 16'h0002) begin
      n_fail++;
      $display("FAIL accept_req: got v=%b cs=%b addr=%h expected 0/1/0002", instr_valid, mem_cs, mem_addr);
    end
    wait_valid(20, n);
    n_checks++;
    if (instr_valid !== 1'b1 || instr_opcode !== 16'h1111 || instr_operand !== 16'h2222 ||
        instr_pc !== 16'h0002) begin
      n_fail++;
      $display("FAIL second_record: got v=%b %h/%h pc=%h expected 1 1111/2222 pc=0002",
               instr_valid, instr_opcode, instr_operand, instr_pc);
    end
  endtask

  task automatic test_branch_hold();
    int n;
    br_en = 1'b1;
    br_target = 16'h0004;
    instr_accept = 1'b1;
    tick();
    br_en = 1'b0;
    n_checks++;
    if (instr_valid !== 1'b0 || mem_cs !== 1'b1 || mem_addr !== 16'h0004) begin
      n_fail++;
      $display("FAIL branch_hold: got v=%b cs=%b addr=%h expected 0/1/0004", instr_valid, mem_cs, mem_addr);
    end
    wait_valid(20, n);
    n_checks++;
    if (instr_valid !== 1'b1 || instr_opcode !== 16'h3333 || instr_operand !== 16'h4444 ||
        instr_pc !== 16'h0004) begin
      n_fail++;
      $display("FAIL branch_record: got v=%b %h/%h pc=%h expected 1 3333/4444 pc=0004",
               instr_valid, instr_opcode, instr_operand, instr_pc);
    end
  endtask

  task automatic test_branch_wait();
    int n;
    bit found;
    lat = 3;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick();
      if (mem_cs === 1'b1 && mem_addr === 16'h0007) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL reach_operand7: got no cs at 0007 expected one within 60 cycles");
    end
    tick();
    tick();
    br_en = 1'b1;
    br_target = 16'h000A;
    cs_log.delete();
    tick();
    br_en = 1'b0;
    n_checks++;
    if (instr_valid !== 1'b0 || mem_cs !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_wait: got v=%b cs=%b busy=%b expected 0/0/1", instr_valid, mem_cs, busy);
    end
    wait_valid(40, n);
    n_checks++;
    if (instr_valid !== 1'b1 || instr_opcode !== 16'h7777 || instr_operand !== 16'h8888 ||
        instr_pc !== 16'h000A) begin
      n_fail++;
      $display("FAIL flush_record: got v=%b %h/%h pc=%h expected 1 7777/8888 pc=000A",
               instr_valid, instr_opcode, instr_operand, instr_pc);
    end
    n_checks++;
    if (cs_log.size() != 2 || cs_log[0] !== 16'h000A || cs_log[1] !== 16'h000B) begin
      n_fail++;
      $display("FAIL flush_cs_addrs: got %0d entries expected 2 (000A,000B)", cs_log.size());
    end
    run = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0 || instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_idle: got busy=%b v=%b expected 0/0", busy, instr_valid);
    end
  endtask

  task automatic test_wrap_and_reset();
    int n;
    lat = 1;
    br_en = 1'b1;
    br_target = 16'hFFFE;
    tick();
    br_en = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || mem_cs !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_branch: got busy=%b cs=%b expected 0/0", busy, mem_cs);
    end
    cs_log.delete();
    run = 1'b1;
    wait_valid(30, n);
    n_checks++;
    if (instr_valid !== 1'b1 || instr_opcode !== 16'h9999 || instr_operand !== 16'hAAAA ||
        instr_pc !== 16'hFFFE) begin
      n_fail++;
      $display("FAIL wrap_record: got v=%b %h/%h pc=%h expected 1 9999/AAAA pc=FFFE",
               instr_valid, instr_opcode, instr_operand, instr_pc);
    end
    n_checks++;
    if (cs_log.size() != 2 || cs_log[0] !== 16'hFFFE || cs_log[1] !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL wrap_cs_addrs: got %0d entries expected 2 (FFFE,FFFF)", cs_log.size());
    end
    tick();
    n_checks++;
    if (mem_cs !== 1'b1 || mem_addr !== 16'h0000) begin
      n_fail++;
      $display("FAIL wrap_next: got cs=%b addr=%h expected 1/0000", mem_cs, mem_addr);
    end
    tick();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (mem_cs !== 1'b0 || busy !== 1'b0 || instr_valid !== 1'b0 || mem_addr !== 16'h0000 ||
        instr_pc !== 16'h0000 || instr_opcode !== 16'h0000) begin
      n_fail++;
      $display("FAIL async_reset: got cs=%b busy=%b v=%b addr=%h pc=%h op=%h expected all zero",
               mem_cs, busy, instr_valid, mem_addr, instr_pc, instr_opcode);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (mem_cs !== 1'b0) begin
        n_fail++;
        $display("FAIL rerelease_cs%0d: got %b expected 0", i, mem_cs);
      end
    end
    tick();
    n_checks++;
    if (mem_cs !== 1'b1 || mem_addr !== 16'h0000) begin
      n_fail++;
      $display("FAIL rerelease_req: got cs=%b addr=%h expected 1/0000", mem_cs, mem_addr);
    end
  endtask

  task automatic test_timeout();
`ifdef FETCH_TIMEOUT_EN
    int n;
    run = 1'b0;
    rom_stuck = 1'b1;
    n = 0;
    while (fetch_err !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    n_checks++;
    if (fetch_err !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_err: got err=%b busy=%b expected 1/0", fetch_err, busy);
    end
    n_checks++;
    if (n < 15 || n > 17) begin
      n_fail++;
      $display("FAIL timeout_cycles: got %0d expected 15..17", n);
    end
    br_en = 1'b1;
    br_target = 16'h0000;
    tick();
    br_en = 1'b0;
    n_checks++;
    if (fetch_err !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_clear: got %b expected 0", fetch_err);
    end
    rom_stuck = 1'b0;
`else
    n_checks++;
    if (fetch_err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_tied: got %b expected 0", fetch_err);
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) rom[i] = 16'h0;
    rom[16'h0000] = 16'h0028;
    rom[16'h0001] = 16'h0005;
    rom[16'h0002] = 16'h1111;
    rom[16'h0003] = 16'h2222;
    rom[16'h0004] = 16'h3333;
    rom[16'h0005] = 16'h4444;
    rom[16'h0006] = 16'h5555;
    rom[16'h0007] = 16'h6666;
    rom[16'h000A] = 16'h7777;
    rom[16'h000B] = 16'h8888;
    rom[16'hFFFE] = 16'h9999;
    rom[16'hFFFF] = 16'hAAAA;

    test_reset();
    test_first_fetch();
    test_hold();
    test_branch_hold();
    test_branch_wait();
    test_wrap_and_reset();
    test_timeout();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
